// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmit and receive blocks.
//
//   uart_state_e : 2-bit frame state (IDLE, START, DATA, STOP)
//   DATA_BITS    : payload bits per 8N1 frame
//   bps_cnt()    : system clocks per bit period (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Clocks per bit. Both sides of a link must use this same function so that
  // the transmitter and receiver agree on the bit period after truncation.
  function automatic int unsigned bps_cnt(input int unsigned clk_fre,
                                          input int unsigned bps);
    return clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
//   Brings the asynchronous serial line into the clock domain and detects the
//   falling edge that marks a potential start bit.
//
//   clk_i        : system clock
//   rst_i        : synchronous active-high reset
//   rxd_i        : asynchronous serial line (idle high)
//   rxd_sync_o   : synchronised line level (second synchroniser flop)
//   start_edge_o : one-cycle pulse on a high-to-low transition of rxd_sync_o
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic rxd_sync_o,
  output logic start_edge_o
);

  logic rxd_s1_q;
  logic rxd_s2_q;
  logic rxd_s3_q;
  logic seeded_q;
  logic armed_q;

  // The three line flops reset to the idle level. Because those reset values
  // are not real observations of the line, edge detection is held off until a
  // genuine high sample has been seen: seeded_q marks that rxd_s1_q now holds
  // a post-reset sample, and armed_q latches once such a sample is high. A
  // line held low through reset release therefore needs to go high and fall
  // again before a start can be detected.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
      seeded_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      rxd_s1_q <= rxd_i;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
      seeded_q <= 1'b1;
      armed_q  <= armed_q | (seeded_q & rxd_s1_q);
    end
  end

  assign rxd_sync_o   = rxd_s2_q;
  assign start_edge_o = armed_q & rxd_s3_q & ~rxd_s2_q;

endmodule

// File: rtl/usart_rx.sv
// -----------------------------------------------------------------------------
// usart_rx
//   8N1 UART receiver: one start bit, eight data bits LSB first, one stop bit.
//   Each bit is sampled once at its centre. A correctly framed byte is
//   presented on uart_data with a one-cycle uart_done strobe; a frame whose
//   stop bit samples low is discarded with a one-cycle frame_err strobe.
//
//   sys_clk   : system clock, rising edge
//   sys_rst   : synchronous active-high reset
//   uart_rxd  : asynchronous serial input, idle high
//   uart_data : last correctly received byte
//   uart_done : one-cycle strobe, uart_data updated this cycle
//   frame_err : one-cycle strobe, stop bit was low, byte dropped
//   rx_busy   : high while a frame is being received (state != IDLE)
//
//   Clocks per bit is SYS_CLK_FRE/BPS and must lie in [4, 65535].
// -----------------------------------------------------------------------------
module usart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FRE = 50_000_000,
  parameter int unsigned BPS         = 9_600
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned BPS_CNT  = bps_cnt(SYS_CLK_FRE, BPS);
  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_MID  = 16'(BPS_CNT / 2 - 1);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  logic rxd_sync;
  logic start_edge;

  uart_state_e state_q,   state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  data_q,    data_d;
  logic        done_q,    done_d;
  logic        err_q,     err_d;

  uart_rx_sync u_sync (
    .clk_i        (sys_clk),
    .rst_i        (sys_rst),
    .rxd_i        (uart_rxd),
    .rxd_sync_o   (rxd_sync),
    .start_edge_o (start_edge)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
        if (start_edge) begin
          state_d = ST_START;
        end
      end

      // Half a bit period in, the start bit must still be low; a high sample
      // means the edge was a glitch and the frame is abandoned silently.
      ST_START: begin
        if (clk_cnt_q == CNT_MID) begin
          clk_cnt_d = 16'd0;
          state_d   = rxd_sync ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      // From the start-bit centre, every full bit period lands on the next
      // bit centre. Bits arrive LSB first, so shifting right leaves the first
      // received bit in bit 0 after eight samples.
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rxd_sync, shift_q[7:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      // Leaving at the stop-bit centre, rather than its end, leaves half a
      // bit of slack to catch the next start edge of a back-to-back frame.
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = 16'd0;
          state_d   = ST_IDLE;
          if (rxd_sync) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        clk_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  assign uart_data = data_q;
  assign uart_done = done_q;
  assign frame_err = err_q;
  // The strobes are registered on the same edge that returns to IDLE, so
  // rx_busy is already low whenever uart_done is high.
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usart_rx.sv
module tb_usart_rx;

  localparam int unsigned CLK_FRE = 1_000_000;
  localparam int unsigned BAUD    = 100_000;
  localparam int          BC      = 10;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;

  usart_rx #(
    .SYS_CLK_FRE (CLK_FRE),
    .BPS         (BAUD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .uart_data (uart_data),
    .uart_done (uart_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic prev_strobe = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [7:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

  // Monitor: pops one expectation per strobe observed on the DUT outputs.
  always @(negedge sys_clk) begin
    exp_t e;
    if (uart_done || frame_err) begin
      check("strobe_exclusive", {31'd0, uart_done & frame_err}, 32'd0);
      check("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual done=%0b err=%0b data=%0h required no strobe",
                 uart_done, frame_err, uart_data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
        check("uart_data", {24'd0, uart_data}, {24'd0, e.data});
        if (uart_done) check("busy_at_done", {31'd0, rx_busy}, 32'd0);
      end
    end
    prev_strobe = uart_done | frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rxd = v;
    wait_cyc(BC);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rxd = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    wait_cyc(2 * BC);
  endtask

  initial begin
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    wait_cyc(3);
    check("reset_data", {24'd0, uart_data}, 32'h0);
    check("reset_done", {31'd0, uart_done}, 32'd0);
    check("reset_err",  {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy},   32'd0);
    sys_rst = 1'b0;
    wait_cyc(5);

    // Single clean frame.
    exp_q.push_back(mk(1'b0, 8'hA5));
    send_frame(8'hA5, 1'b1);
    drain("t1_a5_drain");
    check("t1_busy_after", {31'd0, rx_busy}, 32'd0);

    // Stop bit low: frame error, previous byte retained.
    exp_q.push_back(mk(1'b1, 8'hA5));
    send_frame(8'h3C, 1'b0);
    drain("t4_ferr_drain");
    check("t4_data_hold", {24'd0, uart_data}, 32'hA5);

    // Back-to-back frames, no idle gap.
    exp_q.push_back(mk(1'b0, 8'h00));
    exp_q.push_back(mk(1'b0, 8'hFF));
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("t2_b2b_drain");

    // Three-cycle glitch on an idle line.
    uart_rxd = 1'b0;
    wait_cyc(3);
    uart_rxd = 1'b1;
    wait_cyc(8);
    check("t3_glitch_busy", {31'd0, rx_busy}, 32'd0);
    drain("t3_glitch_quiet");

    // Reset in the middle of data bit 4; the sender shares the reset, so the
    // line goes back to idle at the same moment.
    uart_rxd = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h5A >> i) & 8'h01));
    uart_rxd = 1'b1;
    wait_cyc(BC / 2);
    check("t5_busy_before_rst", {31'd0, rx_busy}, 32'd1);
    sys_rst = 1'b1;
    wait_cyc(1);
    sys_rst = 1'b0;
    check("t5_busy_after_rst", {31'd0, rx_busy}, 32'd0);
    wait_cyc(15 * BC);
    check("t5_no_strobe", exp_q.size(), 32'd0);
    exp_q.push_back(mk(1'b0, 8'h81));
    send_frame(8'h81, 1'b1);
    drain("t5_81_drain");

    // Loopback-style stream at the transmitter's bit timing.
    exp_q.push_back(mk(1'b0, 8'h00));
    exp_q.push_back(mk(1'b0, 8'h55));
    exp_q.push_back(mk(1'b0, 8'hAA));
    exp_q.push_back(mk(1'b0, 8'hFF));
    send_frame(8'h00, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("t6_loop_drain");

    // Line held low through reset release: no start until high then low.
    uart_rxd = 1'b0;
    sys_rst  = 1'b1;
    wait_cyc(3);
    sys_rst  = 1'b0;
    wait_cyc(4 * BC);
    check("t7_low_release_busy", {31'd0, rx_busy}, 32'd0);
    uart_rxd = 1'b1;
    wait_cyc(5);
    exp_q.push_back(mk(1'b0, 8'h3C));
    send_frame(8'h3C, 1'b1);
    drain("t7_3c_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
